instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC loaded at reset.
REQ-002 Parameter: NOP_INSTR, 32'hD503201F, bubble instruction placed in IF/ID.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hazard hold; freezes the PC and the IF/ID register.
REQ-006 IF_ID_Flush  in  1  replaces the next IF/ID contents with NOP_INSTR.
REQ-007 or_out  in  1  taken conditional or unconditional branch; redirects to PC_CB.
REQ-008 PC_CB  in  64  branch target computed in decode.
REQ-009 Branchreg  in  1  register-indirect branch; redirects to branch_reg_target.
REQ-010 branch_reg_target  in  64  BR target (decode read_data1).
REQ-011 imem_req  out  1  instruction memory request.
REQ-012 imem_addr  out  64  fetch address; valid only while imem_req=1.
REQ-013 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-014 imem_rdata  in  32  fetched instruction word.
REQ-015 instruction  out  32  IF/ID instruction to decode.
REQ-016 PC_out_IF_ID  out  64  IF/ID PC of that instruction.
REQ-017 PC_branch_link_out  out  64  PC_out_IF_ID + 4, used as the BL link value.
REQ-018 if_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-019 The FSM SHALL have two states: FETCH (imem_req=1, imem_addr=pc) and HOLD (imem_req=0).
REQ-020 Redirect = (Branchreg | or_out) & !stall; target SHALL be branch_reg_target if Branchreg=1, else PC_CB.
REQ-021 Per-cycle priority SHALL be: redirect > stall > normal progress.
REQ-022 On redirect: pc <= target; IF/ID <= {NOP_INSTR, PC 0, valid 0}; any same-cycle or buffered imem_rdata is discarded; next state FETCH.
REQ-023 FETCH & imem_ready & !stall: IF/ID <= {imem_rdata, pc, valid 1}; pc <= pc+4 (64-bit wrap); stay in FETCH.
REQ-024 FETCH & imem_ready & stall: imem_rdata and pc are captured into a skid buffer; IF/ID and pc hold; next state HOLD.
REQ-025 FETCH & !imem_ready & !stall: IF/ID <= bubble (NOP_INSTR, valid 0); pc holds.
REQ-026 HOLD & !stall: IF/ID <= skid buffer with valid 1; pc <= pc+4; next state FETCH.
REQ-027 With stall=1 and no redirect, the IF/ID register and the pc SHALL hold unchanged.
REQ-028 IF_ID_Flush=1 SHALL force the IF/ID update to NOP_INSTR with valid 0, overriding both stall and REQ-023/026 data; pc update rules are unaffected.
REQ-029 imem_ready SHALL be ignored in HOLD.
REQ-030 Fetch latency: a word accepted in cycle N SHALL appear on the instruction output in cycle N+1.

Reset
REQ-031 While reset=0: pc=RESET_PC; state=FETCH; instruction=NOP_INSTR; PC_out_IF_ID=0; if_valid=0; skid buffer cleared.
REQ-032 imem_req SHALL be 1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-HOLD or mid-fetch SHALL discard all in-flight data asynchronously.

Structure
REQ-034 NOP_INSTR, the INSTR_BYTES=4 constant and the FSM state encoding SHALL reside in the shared package fetch_pkg.
REQ-035 The IF/ID storage SHALL be a sub-module if_id_register (data, PC, valid; with load and flush inputs).
REQ-036 Both PC+4 adders SHALL reuse the existing alu_add.

Verification
REQ-037 Reset release, imem_ready=1 constantly -> imem_addr 0, 4, 8; instruction matches the words one cycle later; if_valid=1.
REQ-038 stall=1 in a cycle where imem_ready=1 at pc 0x10 -> HOLD, imem_req=0; after stall drops, the buffered word appears with PC_out_IF_ID=0x10 and the next imem_addr is 0x14.
REQ-039 or_out=1 with PC_CB=0x100 while fetching 0x20 -> the 0x20 word is discarded; IF/ID=NOP with if_valid=0; next imem_addr=0x100.
REQ-040 Branchreg=1 and or_out=1 together, branch_reg_target=0x400, PC_CB=0x200 -> next imem_addr=0x400.
REQ-041 IF_ID_Flush=1 and stall=1 together -> instruction=NOP_INSTR and if_valid=0; pc unchanged.
REQ-042 pc=0xFFFF_FFFF_FFFF_FFFC with the word accepted -> pc wraps to 0; reset pulsed while in HOLD -> imem_addr=RESET_PC and the skid word never appears on the instruction output.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    // A64 NOP used as the pipeline bubble.
    localparam logic [31:0] NOP_INSTR   = 32'hD503201F;
    localparam int          INSTR_BYTES = 4;

    // FETCH drives a memory request at pc; HOLD parks a returned word in the skid buffer.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bundle.
interface instruction_fetch_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/alu_add.sv
// Plain wrapping adder shared by the datapath.
module alu_add #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag.
// flush wins over load and inserts a NOP bubble.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [63:0] d_pc,
    input  logic        d_valid,
    output logic [31:0] q_instr,
    output logic [63:0] q_pc,
    output logic        q_valid
);

    // IF/ID stage boundary: flush beats load, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_instr <= NOP_INSTR;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_instr <= NOP_INSTR;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, branch redirect, one-entry skid
// buffer for words returned during a stall, and the IF/ID register.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       IF_ID_Flush,
    input  logic                       or_out,
    input  logic [63:0]                PC_CB,
    input  logic                       Branchreg,
    input  logic [63:0]                branch_reg_target,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instruction,
    output logic [63:0]                PC_out_IF_ID,
    output logic [63:0]                PC_branch_link_out,
    output logic                       if_valid
);

    localparam logic [63:0] PC_STEP = 64'(INSTR_BYTES);

    fetch_state_t state, next_state;
    logic [63:0]  pc, pc_next, pc_plus4;
    logic [31:0]  skid_instr;
    logic [63:0]  skid_pc;
    logic         skid_load;
    logic         redirect;
    logic [63:0]  redirect_target;
    logic         ifid_load;
    logic [31:0]  ifid_instr;
    logic [63:0]  ifid_pc;
    logic         ifid_valid;

    assign redirect        = (Branchreg | or_out) & ~stall;
    assign redirect_target = Branchreg ? branch_reg_target : PC_CB;

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    alu_add #(.WIDTH(64)) u_pc_inc (
        .a   (pc),
        .b   (PC_STEP),
        .sum (pc_plus4)
    );

    alu_add #(.WIDTH(64)) u_link_inc (
        .a   (PC_out_IF_ID),
        .b   (PC_STEP),
        .sum (PC_branch_link_out)
    );

    // Next state, next pc and IF/ID load: redirect > stall > normal progress.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        skid_load  = 1'b0;
        ifid_load  = 1'b0;
        ifid_instr = NOP_INSTR;
        ifid_pc    = '0;
        ifid_valid = 1'b0;
        if (redirect) begin
            pc_next    = redirect_target;
            ifid_load  = 1'b1;
            next_state = FETCH;
        end else if (stall) begin
            if (state == FETCH && imem.imem_ready) begin
                skid_load  = 1'b1;
                next_state = HOLD;
            end
        end else begin
            case (state)
                FETCH: begin
                    ifid_load = 1'b1;
                    if (imem.imem_ready) begin
                        ifid_instr = imem.imem_rdata;
                        ifid_pc    = pc;
                        ifid_valid = 1'b1;
                        pc_next    = pc_plus4;
                    end
                end
                HOLD: begin
                    ifid_load  = 1'b1;
                    ifid_instr = skid_instr;
                    ifid_pc    = skid_pc;
                    ifid_valid = 1'b1;
                    pc_next    = pc_plus4;
                    next_state = FETCH;
                end
            endcase
        end
    end

    // FSM state and program counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Skid buffer: catches a word that arrives while decode is stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (skid_load) begin
            skid_instr <= imem.imem_rdata;
            skid_pc    <= pc;
        end
    end

    if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clock   (clock),
        .reset   (reset),
        .load    (ifid_load),
        .flush   (IF_ID_Flush),
        .d_instr (ifid_instr),
        .d_pc    (ifid_pc),
        .d_valid (ifid_valid),
        .q_instr (instruction),
        .q_pc    (PC_out_IF_ID),
        .q_valid (if_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        IF_ID_Flush = 1'b0;
    logic        or_out = 1'b0;
    logic        Branchreg = 1'b0;
    logic [63:0] PC_CB = '0;
    logic [63:0] branch_reg_target = '0;
    logic [31:0] instruction;
    logic [63:0] PC_out_IF_ID;
    logic [63:0] PC_branch_link_out;
    logic        if_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_pc;
    bit          m_held;
    logic [31:0] m_buf_word;
    logic [63:0] m_buf_pc;
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;
    bit          m_valid;

    instruction_fetch_if imem ();

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .IF_ID_Flush        (IF_ID_Flush),
        .or_out             (or_out),
        .PC_CB              (PC_CB),
        .Branchreg          (Branchreg),
        .branch_reg_target  (branch_reg_target),
        .imem               (imem.master),
        .instruction        (instruction),
        .PC_out_IF_ID       (PC_out_IF_ID),
        .PC_branch_link_out (PC_branch_link_out),
        .if_valid           (if_valid)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w_at(input logic [63:0] a);
        return a[31:0] ^ 32'hF900_0000;
    endfunction

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_held     = 1'b0;
        m_buf_word = '0;
        m_buf_pc   = '0;
        m_instr    = NOP_INSTR;
        m_ifpc     = '0;
        m_valid    = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = NOP_INSTR;
        m_ifpc  = '0;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_req"}, 64'(imem.imem_req), 64'(!m_held));
        if (!m_held) check_val({tag, "_addr"}, imem.imem_addr, m_pc);
        check_val({tag, "_instr"}, 64'(instruction), 64'(m_instr));
        check_val({tag, "_pc"}, PC_out_IF_ID, m_ifpc);
        check_val({tag, "_link"}, PC_branch_link_out, m_ifpc + 64'd4);
        check_val({tag, "_valid"}, 64'(if_valid), 64'(m_valid));
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, check after the edge.
    task automatic step(input bit st, input bit fl, input bit oo, input logic [63:0] pcb,
                        input bit br, input logic [63:0] brt, input bit rdy,
                        input logic [31:0] rdata, input string tag);
        bit redir;
        stall             = st;
        IF_ID_Flush       = fl;
        or_out            = oo;
        PC_CB             = pcb;
        Branchreg         = br;
        branch_reg_target = brt;
        imem.imem_ready   = rdy;
        imem.imem_rdata   = rdata;

        redir = (br || oo) && !st;
        if (redir) begin
            m_pc   = br ? brt : pcb;
            m_held = 1'b0;
            model_bubble();
        end else if (st) begin
            if (!m_held && rdy) begin
                m_buf_word = rdata;
                m_buf_pc   = m_pc;
                m_held     = 1'b1;
            end
        end else if (m_held) begin
            m_instr = m_buf_word;
            m_ifpc  = m_buf_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            m_held  = 1'b0;
        end else if (rdy) begin
            m_instr = rdata;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
        end else begin
            model_bubble();
        end
        if (fl) model_bubble();

        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic fetch_ok(input logic [63:0] a, input string tag);
        step(0, 0, 0, '0, 0, '0, 1, w_at(a), tag);
    endtask

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        check_val("reset_instr_nop", 64'(instruction), 64'(NOP_INSTR));
        check_val("reset_addr", imem.imem_addr, RESET_PC);
        reset = 1'b1;

        // Sequential fetch from reset
        check_val("seq_first_addr", imem.imem_addr, 64'h0);
        fetch_ok(64'h0, "seq0");
        check_val("seq0_word", 64'(instruction), 64'(w_at(64'h0)));
        check_val("seq0_valid", 64'(if_valid), 64'd1);
        check_val("seq0_next", imem.imem_addr, 64'h4);
        fetch_ok(64'h4, "seq4");
        check_val("seq4_word", 64'(instruction), 64'(w_at(64'h4)));
        check_val("seq4_next", imem.imem_addr, 64'h8);
        fetch_ok(64'h8, "seq8");
        fetch_ok(64'hC, "seqC");

        // Stall while a word returns at 0x10
        step(1, 0, 0, '0, 0, '0, 1, w_at(64'h10), "skid_in");
        check_val("skid_req_low", 64'(imem.imem_req), 64'd0);
        check_val("skid_ifid_hold", 64'(instruction), 64'(w_at(64'hC)));
        step(0, 0, 0, '0, 0, '0, 1, 32'hDEAD_BEEF, "skid_out");
        check_val("skid_word", 64'(instruction), 64'(w_at(64'h10)));
        check_val("skid_pc", PC_out_IF_ID, 64'h10);
        check_val("skid_next", imem.imem_addr, 64'h14);
        fetch_ok(64'h14, "seq14");
        fetch_ok(64'h18, "seq18");
        fetch_ok(64'h1C, "seq1C");

        // Conditional branch while fetching 0x20
        step(0, 0, 1, 64'h100, 0, '0, 1, w_at(64'h20), "br_cb");
        check_val("br_cb_nop", 64'(instruction), 64'(NOP_INSTR));
        check_val("br_cb_valid", 64'(if_valid), 64'd0);
        check_val("br_cb_addr", imem.imem_addr, 64'h100);

        // Register branch takes precedence over PC_CB
        step(0, 0, 1, 64'h200, 1, 64'h400, 1, w_at(64'h100), "br_reg");
        check_val("br_reg_addr", imem.imem_addr, 64'h400);
        fetch_ok(64'h400, "seq400");

        // Flush together with stall
        step(1, 1, 0, '0, 0, '0, 0, 32'h1234_5678, "flush_stall");
        check_val("flush_nop", 64'(instruction), 64'(NOP_INSTR));
        check_val("flush_valid", 64'(if_valid), 64'd0);
        check_val("flush_pc_hold", imem.imem_addr, 64'h404);

        // PC wrap
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 0, '0, "wrap_br");
        fetch_ok(64'hFFFF_FFFF_FFFF_FFFC, "wrap");
        check_val("wrap_pc", PC_out_IF_ID, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_addr", imem.imem_addr, 64'h0);
        check_val("wrap_link", PC_branch_link_out, 64'h0);

        // Reset while a word sits in the skid buffer
        step(1, 0, 0, '0, 0, '0, 1, 32'h5A5A_C3C3, "hold_rst");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_instr", 64'(instruction), 64'(NOP_INSTR));
        check_val("async_rst_valid", 64'(if_valid), 64'd0);
        check_val("async_rst_req", 64'(imem.imem_req), 64'd1);
        check_val("async_rst_addr", imem.imem_addr, RESET_PC);
        #2 reset = 1'b1;
        step(0, 0, 0, '0, 0, '0, 0, '0, "post_rst");
        check_val("post_rst_no_skid", 64'(instruction), 64'(NOP_INSTR));
        fetch_ok(64'h0, "post_rst_fetch");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          st, fl, oo, br, rdy;
            logic [63:0] pcb, brt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            oo  = ($urandom_range(0, 11) == 0);
            br  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            pcb = {$urandom, $urandom} & ~64'h3;
            brt = {$urandom, $urandom} & ~64'h3;
            step(st, fl, oo, pcb, br, brt, rdy, $urandom, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
